// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder built from two half adders and an OR.
//   a, b, c : addend bits and carry-in
//   sum     : a ^ b ^ c
//   carry   : majority(a, b, c)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic hs1;
  logic hc1;
  logic hc2;

  // First half adder on the operands, second adds the incoming carry.
  assign hs1   = a ^ b;
  assign hc1   = a & b;
  assign sum   = hs1 ^ c;
  assign hc2   = hs1 & c;
  assign carry = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, only honoured in IDLE
//   a, b  : operands, captured on accepted start
//   cin   : carry-in, captured on accepted start
//   busy  : high while shifting and during the done cycle
//   done  : one-cycle pulse when sum/cout are valid
//   sum   : result, held until the next accepted start
//   cout  : final carry-out, held with sum
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_sum;
  logic               fa_carry;

  // Single shared adder cell fed by the operand LSBs and the carry flop.
  fa_cell u_fa (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sa_d             = sa_q >> 1;
        sb_d             = sb_q >> 1;
        // Result enters at the MSB so after WIDTH shifts bit 0 is the LSB.
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_sum;
        carry_d          = fa_carry;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they track the state register.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 add. inj>0 pulses a bogus start at that busy cycle; hold = idle cycles checked after done.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input int inj, input int hold);
    logic [8:0] exp;
    int n;
    bit got;
    exp = 9'(ta) + 9'(tb) + 9'(tc);
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    n = 1;
    got = 1'b0;
    while (n < 40 && !got) begin
      if (done8) begin
        got = 1'b1;
      end else begin
        check("busy8_during", 32'(busy8), 32'd1);
        if (n == inj) begin
          start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        end
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        n++;
      end
    end
    check("done8_seen", 32'(got), 32'd1);
    check("latency8", 32'(n), 32'd9);
    check("sum8", 32'(sum8), 32'(exp[7:0]));
    check("cout8", 32'(cout8), 32'(exp[8]));
    check("busy8_at_done", 32'(busy8), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done8_pulse", 32'(done8), 32'd0);
      check("busy8_idle", 32'(busy8), 32'd0);
      check("sum8_hold", 32'(sum8), 32'(exp[7:0]));
      check("cout8_hold", 32'(cout8), 32'(exp[8]));
    end
  endtask

  // One WIDTH=1 add against the full-adder truth table.
  task automatic run1(input logic ta, input logic tb, input logic tc);
    int n;
    bit got;
    logic [1:0] exp;
    exp = 2'(ta) + 2'(tb) + 2'(tc);
    @(negedge clk);
    start1 = 1'b1; a1 = ta; b1 = tb; cin1 = tc;
    @(negedge clk);
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    n = 1;
    got = 1'b0;
    while (n < 20 && !got) begin
      if (done1) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("done1_seen", 32'(got), 32'd1);
    check("latency1", 32'(n), 32'd2);
    check("sum1", 32'(sum1), 32'(exp[0]));
    check("cout1", 32'(cout1), 32'(exp[1]));
    @(negedge clk);
    check("done1_pulse", 32'(done1), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8", 32'(sum8), 32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_sum1", 32'(sum1), 32'd0);

    // Directed cases.
    run8(8'h00, 8'h00, 1'b0, 0, 1);
    run8(8'hFF, 8'h01, 1'b0, 0, 1);
    run8(8'hA5, 8'h5A, 1'b1, 0, 3);
    run8(8'h3C, 8'h42, 1'b0, 0, 4);
    run8(8'h10, 8'h20, 1'b0, 3, 2);
    run8(8'hFF, 8'hFF, 1'b1, 8, 1);

    // Reset in the middle of an add discards it.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h99; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (n < 4) begin
      @(negedge clk);
      n++;
    end
    check("busy8_pre_rst", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy8", 32'(busy8), 32'd0);
    check("midrst_done8", 32'(done8), 32'd0);
    check("midrst_sum8", 32'(sum8), 32'd0);
    check("midrst_cout8", 32'(cout8), 32'd0);
    @(negedge clk);
    check("midrst_stay_idle", 32'(busy8), 32'd0);
    run8(8'h3C, 8'h42, 1'b0, 0, 1);

    // Random adds with occasional ignored starts and variable hold.
    for (int i = 0; i < 150; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom),
           int'($urandom_range(0, 10)), int'($urandom_range(1, 3)));
    end

    // WIDTH=1 truth table.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] bits;
      bits = 3'(v);
      run1(bits[2], bits[1], bits[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
